reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised multi-port register file for the datapath: NUM_REGS x BUS_WIDTH storage, one write port, two combinational read ports.
- Adds an asynchronous active-low reset, an optional hard-wired zero register, and optional write-to-read bypass.
- Adds a per-register busy scoreboard so the control unit can detect read-after-write hazards on multi-cycle results.
- Sits between decode (read addresses, reservation) and writeback (write port).

Parameters:
- BUS_WIDTH, 16, data width of every register and bus.
- NUM_REGS, 8, number of registers; power of two, minimum 2.
- ZERO_REG, 1, when 1: register 0 reads 0, ignores writes, is never busy.
- BYPASS, 1, when 1: same-cycle write data forwarded to matching read ports, and the matching busy flag is masked.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- regWrite  input  1  write enable, sampled at posedge clk
- wAddr  input  ADDR_W  write address; ADDR_W = clog2(NUM_REGS)
- wData  input  BUS_WIDTH  write data
- rAddrA  input  ADDR_W  read address, port A
- rAddrB  input  ADDR_W  read address, port B
- outA  output  BUS_WIDTH  read data, port A (combinational)
- outB  output  BUS_WIDTH  read data, port B (combinational)
- reserve  input  1  mark resAddr busy, sampled at posedge clk
- resAddr  input  ADDR_W  register to reserve
- busyA  output  1  register at rAddrA has a pending result
- busyB  output  1  register at rAddrB has a pending result
- busyAny  output  1  OR of all busy flags

Behaviour:
Reset
- rst_n low, asynchronously: all registers clear to 0 and all busy flags clear.
- Outputs therefore read 0 during reset; busyA, busyB and busyAny are 0.
- Operations resume on the first posedge after rst_n rises.
- A write or reserve whose posedge coincides with rst_n low is discarded.

Write
- On posedge, if regWrite=1: mem[wAddr] <= wData.
- Write latency is one cycle; data is visible through storage from the next cycle.
- ZERO_REG=1 and wAddr=0: the write is dropped.

Read
- outX = mem[rAddrX], combinational. Both ports may read the same address.
- ZERO_REG=1 and rAddrX=0: outX = 0 regardless of stored contents.
- BYPASS=1, regWrite=1, wAddr=rAddrX, and the address is not the zero register: outX = wData in the same cycle.
- BYPASS=0: the old value is returned until the next cycle.

Scoreboard
- Posedge with reserve=1: busy[resAddr] <= 1.
- Posedge with regWrite=1: busy[wAddr] <= 0.
- reserve and regWrite on the same address in the same cycle: busy ends at 1 (new reservation wins); the data write still occurs.
- reserve and regWrite on different addresses: both take effect.
- Reserving an already-busy register is legal; the flag stays 1 and there is no count.
- Writing a non-busy register is legal; the flag stays 0.
- busyX = busy[rAddrX], except:
  - BYPASS=1 with regWrite=1 and wAddr=rAddrX: busyX = 0 that cycle, unless reserve=1 also targets rAddrX.
  - ZERO_REG=1 and rAddrX=0: busyX = 0 always.
- busyAny = OR of stored busy flags; it does not apply the bypass mask.

Width rules
- No arithmetic; addresses are unsigned.
- Addresses are always in range because NUM_REGS is a power of two.

Decomposition:
- Shared package rf_pkg:
  - clog2 function used for ADDR_W.
  - Default BUS_WIDTH and NUM_REGS constants.
  - Typedefs rf_addr_t and rf_data_t.
- One sub-module, rf_cell: a single BUS_WIDTH register with write enable, asynchronous active-low reset and a busy flip-flop with set/clear priority (set wins).
  - Instantiated NUM_REGS times via generate.
  - Read muxes, bypass and zero-register logic live in reg_file_sb.

Test Plan:
- Reset: preload r3=0x1234 and r5 busy, pulse rst_n low mid-cycle -> outA (rAddrA=3) = 0 immediately, busyAny = 0, no clock edge required.
- Write/read: write r2=0xBEEF at cycle 1, read A=2, B=2 at cycle 2 -> outA = outB = 0xBEEF; with BYPASS=0, reading r2 in cycle 1 returns the old value 0.
- Zero register: write r0=0xFFFF, reserve r0 -> outA (rAddrA=0) = 0, busyA = 0; repeat with ZERO_REG=0 -> outA = 0xFFFF, busyA = 1.
- Bypass: BYPASS=1, r4=0x0011, same cycle regWrite wAddr=4 wData=0x00AA with rAddrB=4 -> outB = 0x00AA and busyB = 0 that cycle; stored value 0x00AA next cycle.
- Scoreboard: reserve r6 at cycle 1 -> busyA (rAddrA=6) = 1 from cycle 2; write r6 at cycle 4 -> busyA = 0 from cycle 5, busyAny = 0.
- Collision: reserve r7 and write r7=0x5555 in the same cycle -> next cycle r7 = 0x5555 and busy[7] = 1; a simultaneous write to r1 and reserve of r7 -> r1 not busy, r7 busy.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants, types and helpers for the register file and its cells.
package rf_pkg;

  localparam int unsigned RF_BUS_WIDTH = 16;
  localparam int unsigned RF_NUM_REGS  = 8;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r = r + 1;
    end
    return r;
  endfunction

  typedef logic [clog2(RF_NUM_REGS)-1:0] rf_addr_t;
  typedef logic [RF_BUS_WIDTH-1:0]       rf_data_t;

endpackage

// File: rtl/rf_cell.sv
// One storage register with write enable plus its scoreboard busy flag.
module rf_cell #(
  parameter int unsigned BUS_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_we,
  input  logic [BUS_WIDTH-1:0] i_wdata,
  input  logic                 i_set,
  input  logic                 i_clr,
  output logic [BUS_WIDTH-1:0] o_data,
  output logic                 o_busy
);

  logic [BUS_WIDTH-1:0] r_data;
  logic                 r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_we) begin
      r_data <= i_wdata;
    end
  end

  // A new reservation outranks the completing write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
    end else if (i_set) begin
      r_busy <= 1'b1;
    end else if (i_clr) begin
      r_busy <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_busy = r_busy;

endmodule

// File: rtl/reg_file_sb.sv
// Two-read / one-write register file with zero register, write bypass and busy scoreboard.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = RF_BUS_WIDTH,
  parameter int unsigned NUM_REGS  = RF_NUM_REGS,
  parameter bit          ZERO_REG  = 1'b1,
  parameter bit          BYPASS    = 1'b1,
  localparam int unsigned ADDR_W   = clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 regWrite,
  input  logic [ADDR_W-1:0]    wAddr,
  input  logic [BUS_WIDTH-1:0] wData,
  input  logic [ADDR_W-1:0]    rAddrA,
  input  logic [ADDR_W-1:0]    rAddrB,
  output logic [BUS_WIDTH-1:0] outA,
  output logic [BUS_WIDTH-1:0] outB,
  input  logic                 reserve,
  input  logic [ADDR_W-1:0]    resAddr,
  output logic                 busyA,
  output logic                 busyB,
  output logic                 busyAny
);

  logic [BUS_WIDTH-1:0] w_data [NUM_REGS];
  logic [NUM_REGS-1:0]  w_busy;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
    logic w_is_zero;
    logic w_we;
    logic w_set;

    assign w_is_zero = ZERO_REG && (i == 0);
    assign w_we      = regWrite && (wAddr == ADDR_W'(i)) && !w_is_zero;
    assign w_set     = reserve && (resAddr == ADDR_W'(i)) && !w_is_zero;

    rf_cell #(
      .BUS_WIDTH(BUS_WIDTH)
    ) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_we   (w_we),
      .i_wdata(wData),
      .i_set  (w_set),
      .i_clr  (w_we),
      .o_data (w_data[i]),
      .o_busy (w_busy[i])
    );
  end

  logic w_zero_a, w_zero_b;
  logic w_fwd_a, w_fwd_b;
  logic w_res_a, w_res_b;

  assign w_zero_a = ZERO_REG && (rAddrA == '0);
  assign w_zero_b = ZERO_REG && (rAddrB == '0);
  assign w_fwd_a  = BYPASS && regWrite && (wAddr == rAddrA);
  assign w_fwd_b  = BYPASS && regWrite && (wAddr == rAddrB);
  assign w_res_a  = reserve && (resAddr == rAddrA);
  assign w_res_b  = reserve && (resAddr == rAddrB);

  always_comb begin
    outA = w_data[rAddrA];
    outB = w_data[rAddrB];
    if (w_fwd_a) outA = wData;
    if (w_fwd_b) outB = wData;
    if (w_zero_a) outA = '0;
    if (w_zero_b) outB = '0;
  end

  // Forwarded reads hide the flag the write is about to clear, unless it is re-reserved.
  always_comb begin
    busyA = w_busy[rAddrA];
    busyB = w_busy[rAddrB];
    if (w_fwd_a && !w_res_a) busyA = 1'b0;
    if (w_fwd_b && !w_res_b) busyB = 1'b0;
    if (w_zero_a) busyA = 1'b0;
    if (w_zero_b) busyB = 1'b0;
  end

  assign busyAny = |w_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed test of reg_file_sb: one instance with zero reg + bypass, one with neither.
module tb_reg_file_sb;
  import rf_pkg::*;

  logic     clk;
  logic     rst_n;
  logic     regWrite;
  rf_addr_t wAddr;
  rf_data_t wData;
  rf_addr_t rAddrA;
  rf_addr_t rAddrB;
  logic     reserve;
  rf_addr_t resAddr;

  rf_data_t outA, outB, nz_outA, nz_outB;
  logic     busyA, busyB, busyAny, nz_busyA, nz_busyB, nz_busyAny;

  int checks = 0;
  int errors = 0;

  reg_file_sb #(
    .BUS_WIDTH(16), .NUM_REGS(8), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .regWrite(regWrite), .wAddr(wAddr), .wData(wData),
    .rAddrA(rAddrA), .rAddrB(rAddrB), .outA(outA), .outB(outB),
    .reserve(reserve), .resAddr(resAddr), .busyA(busyA), .busyB(busyB), .busyAny(busyAny)
  );

  reg_file_sb #(
    .BUS_WIDTH(16), .NUM_REGS(8), .ZERO_REG(1'b0), .BYPASS(1'b0)
  ) u_nz (
    .clk(clk), .rst_n(rst_n), .regWrite(regWrite), .wAddr(wAddr), .wData(wData),
    .rAddrA(rAddrA), .rAddrB(rAddrB), .outA(nz_outA), .outB(nz_outB),
    .reserve(reserve), .resAddr(resAddr), .busyA(nz_busyA), .busyB(nz_busyB),
    .busyAny(nz_busyAny)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    regWrite = 1'b0;
    reserve  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; regWrite = 1'b0; wAddr = '0; wData = '0;
    rAddrA = '0; rAddrB = '0; reserve = 1'b0; resAddr = '0;
    #12;
    chk("rst_outA", outA, 16'h0);
    chk("rst_busyAny", {15'b0, busyAny}, 16'h0);
    chk("rst_nz_outA", nz_outA, 16'h0);
    rst_n = 1'b1;

    // Preload r3 and reserve r5, then reset asynchronously mid-cycle.
    tick();
    regWrite = 1'b1; wAddr = 3'd3; wData = 16'h1234; reserve = 1'b1; resAddr = 3'd5;
    tick();
    idle(); rAddrA = 3'd3; #1;
    chk("pre_outA", outA, 16'h1234);
    chk("pre_busyAny", {15'b0, busyAny}, 16'h1);
    #2 rst_n = 1'b0; #1;
    chk("async_outA", outA, 16'h0);
    chk("async_busyAny", {15'b0, busyAny}, 16'h0);
    chk("async_nz_busyAny", {15'b0, nz_busyAny}, 16'h0);
    // A write across a posedge held in reset must be discarded.
    regWrite = 1'b1; wAddr = 3'd3; wData = 16'hAAAA;
    tick();
    idle(); rst_n = 1'b1;
    tick(); #1;
    chk("rst_discard", outA, 16'h0);

    // Write r2, read both ports; bypass vs. old value in the write cycle.
    regWrite = 1'b1; wAddr = 3'd2; wData = 16'hBEEF; rAddrA = 3'd2; rAddrB = 3'd2; #1;
    chk("wr_byp_outA", outA, 16'hBEEF);
    chk("wr_nobyp_outA", nz_outA, 16'h0);
    tick();
    idle(); #1;
    chk("rd_outA", outA, 16'hBEEF);
    chk("rd_outB", outB, 16'hBEEF);
    chk("rd_nz_outB", nz_outB, 16'hBEEF);

    // Zero register: write and reserve r0.
    regWrite = 1'b1; wAddr = 3'd0; wData = 16'hFFFF; reserve = 1'b1; resAddr = 3'd0;
    tick();
    idle(); rAddrA = 3'd0; #1;
    chk("zr_outA", outA, 16'h0);
    chk("zr_busyA", {15'b0, busyA}, 16'h0);
    chk("zr_busyAny", {15'b0, busyAny}, 16'h0);
    chk("nz_r0_outA", nz_outA, 16'hFFFF);
    chk("nz_r0_busyA", {15'b0, nz_busyA}, 16'h1);
    regWrite = 1'b1; wAddr = 3'd0; wData = 16'h0;
    tick();
    idle(); #1;
    chk("nz_r0_clr", {15'b0, nz_busyAny}, 16'h0);

    // Bypass: r4 holds 0x0011 and is busy, then the result arrives.
    regWrite = 1'b1; wAddr = 3'd4; wData = 16'h0011; reserve = 1'b1; resAddr = 3'd4;
    tick();
    idle(); rAddrB = 3'd4; #1;
    chk("col4_busyB", {15'b0, busyB}, 16'h1);
    chk("col4_outB", outB, 16'h0011);
    regWrite = 1'b1; wAddr = 3'd4; wData = 16'h00AA; #1;
    chk("byp_outB", outB, 16'h00AA);
    chk("byp_busyB", {15'b0, busyB}, 16'h0);
    chk("byp_busyAny", {15'b0, busyAny}, 16'h1);
    chk("nobyp_outB", nz_outB, 16'h0011);
    chk("nobyp_busyB", {15'b0, nz_busyB}, 16'h1);
    // Write plus re-reservation of the same register keeps busy visible.
    reserve = 1'b1; resAddr = 3'd4; #1;
    chk("byp_resv_busyB", {15'b0, busyB}, 16'h1);
    reserve = 1'b0;
    tick();
    idle(); #1;
    chk("byp_store_outB", outB, 16'h00AA);
    chk("byp_store_busyB", {15'b0, busyB}, 16'h0);

    // Scoreboard lifetime on r6.
    rAddrA = 3'd6; reserve = 1'b1; resAddr = 3'd6; #1;
    chk("sb_pre_busyA", {15'b0, busyA}, 16'h0);
    tick();
    idle(); #1;
    chk("sb_c2_busyA", {15'b0, busyA}, 16'h1);
    chk("sb_c2_busyAny", {15'b0, busyAny}, 16'h1);
    tick(); tick();
    chk("sb_c4_busyA", {15'b0, busyA}, 16'h1);
    regWrite = 1'b1; wAddr = 3'd6; wData = 16'h6666; #1;
    chk("sb_wr_busyA", {15'b0, busyA}, 16'h0);
    chk("sb_wr_nz_busyA", {15'b0, nz_busyA}, 16'h1);
    chk("sb_wr_busyAny", {15'b0, busyAny}, 16'h1);
    tick();
    idle(); #1;
    chk("sb_c5_busyA", {15'b0, busyA}, 16'h0);
    chk("sb_c5_busyAny", {15'b0, busyAny}, 16'h0);
    chk("sb_c5_outA", outA, 16'h6666);

    // Collision on r7, then independent write r1 / reserve r7.
    regWrite = 1'b1; wAddr = 3'd7; wData = 16'h5555; reserve = 1'b1; resAddr = 3'd7;
    tick();
    idle(); rAddrA = 3'd7; #1;
    chk("col_outA", outA, 16'h5555);
    chk("col_busyA", {15'b0, busyA}, 16'h1);
    regWrite = 1'b1; wAddr = 3'd7; wData = 16'h5555;
    tick();
    regWrite = 1'b1; wAddr = 3'd1; wData = 16'h0101; reserve = 1'b1; resAddr = 3'd7;
    tick();
    idle(); rAddrA = 3'd1; rAddrB = 3'd7; #1;
    chk("diff_outA", outA, 16'h0101);
    chk("diff_busyA", {15'b0, busyA}, 16'h0);
    chk("diff_busyB", {15'b0, busyB}, 16'h1);
    chk("diff_outB", outB, 16'h5555);
    chk("diff_nz_busyB", {15'b0, nz_busyB}, 16'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
